// File: rtl/ram_port_arbiter_if.sv
// Bundle of the CPU, debug and RAM-side signals that pass through ram_port_arbiter.
// Handshake: an access is accepted in any cycle where req & gnt are both high at the
// rising edge. Until that edge the requester holds req/we/addr/wdata stable.
interface ram_port_arbiter_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_gnt;
    logic              cpu_stall;
    logic              cpu_rvalid;
    logic [DATA_W-1:0] cpu_rdata;

    logic              dbg_req;
    logic              dbg_we;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_wdata;
    logic              dbg_gnt;
    logic              dbg_rvalid;
    logic [DATA_W-1:0] dbg_rdata;
    logic              dbg_lock;

    logic [ADDR_W-1:0] ram_address;
    logic [DATA_W-1:0] ram_data;
    logic              ram_rden;
    logic              ram_wren;
    logic [DATA_W-1:0] ram_q;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_gnt, cpu_stall, cpu_rvalid, cpu_rdata,
        input  dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_lock,
        output dbg_gnt, dbg_rvalid, dbg_rdata,
        output ram_address, ram_data, ram_rden, ram_wren,
        input  ram_q
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_gnt, cpu_stall, cpu_rvalid, cpu_rdata,
        output dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_lock,
        input  dbg_gnt, dbg_rvalid, dbg_rdata,
        input  ram_address, ram_data, ram_rden, ram_wren,
        output ram_q
    );
endinterface

// File: rtl/ram_port_arbiter.sv
// Shares the single-port data RAM between the CPU load/store path and the debug port:
// one access per cycle, CPU priority with bounded debug wait, tagged read returns.
module ram_port_arbiter #(
    parameter int ADDR_W       = 10,
    parameter int DATA_W       = 32,
    parameter int RD_LATENCY   = 1,   // 1 or 2
    parameter int STARVE_LIMIT = 4    // 1..15
) (
    input  logic                MAX10_CLK1_50,
    input  logic                reset,
    ram_port_arbiter_if.slave   bus,
    output logic [3:0]          starve_cnt
);
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic                  starved;
    logic                  cpu_win;
    logic                  dbg_win;
    logic                  rd_accept;
    logic                  rd_accept_dbg;
    logic [RD_LATENCY-1:0] tag_v;
    logic [RD_LATENCY-1:0] tag_dbg;
    logic                  tail_v;
    logic                  tail_dbg;

    assign starved = (starve_cnt == LIMIT) && bus.dbg_req;

    // Lock beats everything and blocks the CPU even when debug is idle.
    always_comb begin
        cpu_win = 1'b0;
        dbg_win = 1'b0;
        if (!reset) begin
            if (bus.dbg_lock) begin
                dbg_win = bus.dbg_req;
            end else if (starved) begin
                dbg_win = 1'b1;
            end else if (bus.cpu_req) begin
                cpu_win = 1'b1;
            end else begin
                dbg_win = bus.dbg_req;
            end
        end
    end

    assign rd_accept     = (cpu_win && !bus.cpu_we) || (dbg_win && !bus.dbg_we);
    assign rd_accept_dbg = dbg_win;

    always_comb begin
        bus.cpu_gnt     = cpu_win;
        bus.dbg_gnt     = dbg_win;
        bus.cpu_stall   = !reset && bus.cpu_req && !cpu_win;
        bus.ram_address = dbg_win ? bus.dbg_addr  : bus.cpu_addr;
        bus.ram_data    = dbg_win ? bus.dbg_wdata : bus.cpu_wdata;
        bus.ram_wren    = (cpu_win && bus.cpu_we) || (dbg_win && bus.dbg_we);
        bus.ram_rden    = rd_accept;
    end

    always_ff @(posedge MAX10_CLK1_50) begin
        if (reset) begin
            starve_cnt <= 4'd0;
        end else if (!bus.dbg_req || dbg_win) begin
            starve_cnt <= 4'd0;
        end else if (starve_cnt != LIMIT) begin
            starve_cnt <= starve_cnt + 4'd1;
        end
    end

    // Owner tags travel alongside the RAM's read pipeline; the tail lines up with ram_q.
    always_ff @(posedge MAX10_CLK1_50) begin
        if (reset) begin
            tag_v   <= '0;
            tag_dbg <= '0;
        end else begin
            tag_v   <= RD_LATENCY'({tag_v, rd_accept});
            tag_dbg <= RD_LATENCY'({tag_dbg, rd_accept_dbg});
        end
    end

    assign tail_v   = tag_v[RD_LATENCY-1];
    assign tail_dbg = tag_dbg[RD_LATENCY-1];

    always_comb begin
        bus.cpu_rvalid = !reset && tail_v && !tail_dbg;
        bus.dbg_rvalid = !reset && tail_v && tail_dbg;
        bus.cpu_rdata  = bus.cpu_rvalid ? bus.ram_q : '0;
        bus.dbg_rdata  = bus.dbg_rvalid ? bus.ram_q : '0;
    end
endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: directed scenarios with literal expectations, then random
// traffic checked every cycle against a transaction-level model of arbitration and returns.
module tb_ram_port_arbiter;
  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;
  localparam int RD_LAT = 2;
  localparam int LIMIT  = 4;

  logic clk;
  logic reset;
  logic [3:0] dut_starve;

  ram_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  ram_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LATENCY(RD_LAT), .STARVE_LIMIT(LIMIT)
  ) dut (
    .MAX10_CLK1_50(clk),
    .reset(reset),
    .bus(bus),
    .starve_cnt(dut_starve)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #10 clk = ~clk;

  // ---------------- RAM environment ----------------
  logic [DATA_W-1:0] mem [1024];
  logic [DATA_W-1:0] rpipe [RD_LAT];

  always @(posedge clk) begin
    if (bus.ram_wren) mem[bus.ram_address] <= bus.ram_data;
    rpipe[0] <= bus.ram_rden ? mem[bus.ram_address] : 32'hBAD0_BAD0;
    for (int k = 1; k < RD_LAT; k++) rpipe[k] <= rpipe[k-1];
  end
  assign bus.ram_q = rpipe[RD_LAT-1];

  // ---------------- scoreboard bookkeeping ----------------
  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at time %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    int                due;
    bit                to_dbg;
    logic [DATA_W-1:0] data;
  } ret_t;

  ret_t              ret_q [$];
  logic [DATA_W-1:0] m_mem [1024];
  int                m_wait = 0;
  int                cyc = 0;
  logic              e_cg, e_dg, e_crv, e_drv;
  logic [DATA_W-1:0] e_crd, e_drd;
  ret_t              ent;

  always @(negedge clk) begin
    // Winner from the priority rules and the debug wait length.
    e_cg = 1'b0;
    e_dg = 1'b0;
    if (!reset) begin
      if (bus.dbg_lock) e_dg = bus.dbg_req;
      else if (bus.dbg_req && m_wait >= LIMIT) e_dg = 1'b1;
      else if (bus.cpu_req) e_cg = 1'b1;
      else e_dg = bus.dbg_req;
    end
    e_crv = 1'b0; e_drv = 1'b0; e_crd = '0; e_drd = '0;
    if (!reset && ret_q.size() > 0 && ret_q[0].due == cyc) begin
      if (ret_q[0].to_dbg) begin e_drv = 1'b1; e_drd = ret_q[0].data; end
      else begin e_crv = 1'b1; e_crd = ret_q[0].data; end
    end

    chk("m_cpu_gnt",    bus.cpu_gnt, e_cg);
    chk("m_dbg_gnt",    bus.dbg_gnt, e_dg);
    chk("m_cpu_stall",  bus.cpu_stall, !reset && bus.cpu_req && !e_cg);
    chk("m_ram_wren",   bus.ram_wren, (e_cg && bus.cpu_we) || (e_dg && bus.dbg_we));
    chk("m_ram_rden",   bus.ram_rden, (e_cg && !bus.cpu_we) || (e_dg && !bus.dbg_we));
    chk("m_ram_addr",   32'(bus.ram_address), 32'(e_dg ? bus.dbg_addr : bus.cpu_addr));
    chk("m_ram_data",   bus.ram_data, e_dg ? bus.dbg_wdata : bus.cpu_wdata);
    chk("m_cpu_rvalid", bus.cpu_rvalid, e_crv);
    chk("m_dbg_rvalid", bus.dbg_rvalid, e_drv);
    chk("m_cpu_rdata",  bus.cpu_rdata, e_crd);
    chk("m_dbg_rdata",  bus.dbg_rdata, e_drd);
    chk("m_starve",     32'(dut_starve), 32'(m_wait));

    // Advance the model to the state it has after the coming rising edge.
    if (ret_q.size() > 0 && ret_q[0].due == cyc) void'(ret_q.pop_front());
    if (reset) begin
      ret_q.delete();
      m_wait = 0;
    end else begin
      if (e_cg || e_dg) begin
        if (e_dg ? bus.dbg_we : bus.cpu_we) begin
          m_mem[e_dg ? bus.dbg_addr : bus.cpu_addr] = e_dg ? bus.dbg_wdata : bus.cpu_wdata;
        end else begin
          ent.due    = cyc + RD_LAT;
          ent.to_dbg = e_dg;
          ent.data   = m_mem[e_dg ? bus.dbg_addr : bus.cpu_addr];
          ret_q.push_back(ent);
        end
      end
      if (!bus.dbg_req || e_dg) m_wait = 0;
      else if (m_wait < LIMIT) m_wait = m_wait + 1;
    end
    cyc++;
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cpu(input logic req, input logic we, input int addr, input logic [31:0] wd);
    bus.cpu_req = req; bus.cpu_we = we; bus.cpu_addr = ADDR_W'(addr); bus.cpu_wdata = wd;
  endtask

  task automatic set_dbg(input logic req, input logic we, input int addr, input logic [31:0] wd);
    bus.dbg_req = req; bus.dbg_we = we; bus.dbg_addr = ADDR_W'(addr); bus.dbg_wdata = wd;
  endtask

  logic c_done, d_done;

  initial begin
    for (int i = 0; i < 1024; i++) begin
      mem[i]   = 32'(i) * 32'h11;
      m_mem[i] = 32'(i) * 32'h11;
    end
    for (int k = 0; k < RD_LAT; k++) rpipe[k] = '0;
    reset = 1'b1;
    bus.dbg_lock = 1'b0;
    set_cpu(1'b1, 1'b1, 5, 32'hDEAD_BEEF);
    set_dbg(1'b1, 1'b0, 7, 32'h0);

    // Reset held with both requesting: everything quiet.
    repeat (2) begin
      @(negedge clk);
      chk("rst_cpu_gnt", bus.cpu_gnt, 1'b0);
      chk("rst_dbg_gnt", bus.dbg_gnt, 1'b0);
      chk("rst_stall", bus.cpu_stall, 1'b0);
      chk("rst_wren", bus.ram_wren, 1'b0);
      chk("rst_rden", bus.ram_rden, 1'b0);
      chk("rst_cpu_rvalid", bus.cpu_rvalid, 1'b0);
      chk("rst_dbg_rvalid", bus.dbg_rvalid, 1'b0);
      chk("rst_cpu_rdata", bus.cpu_rdata, 32'h0);
      chk("rst_dbg_rdata", bus.dbg_rdata, 32'h0);
      step();
    end
    reset = 1'b0;

    // CPU write 0xDEADBEEF to 5, then read it back.
    @(negedge clk);
    chk("first_cpu_gnt", bus.cpu_gnt, 1'b1);
    chk("wr_wren", bus.ram_wren, 1'b1);
    chk("wr_addr", 32'(bus.ram_address), 32'd5);
    chk("wr_data", bus.ram_data, 32'hDEAD_BEEF);
    step(); bus.cpu_we = 1'b0;
    @(negedge clk);
    chk("rd_cpu_gnt", bus.cpu_gnt, 1'b1);
    chk("rd_rden", bus.ram_rden, 1'b1);
    step(); bus.cpu_req = 1'b0;
    @(negedge clk);
    chk("idle_cpu_dbg_gnt", bus.dbg_gnt, 1'b1);
    step(); bus.dbg_req = 1'b0;
    @(negedge clk);
    chk("raw_cpu_rvalid", bus.cpu_rvalid, 1'b1);
    chk("raw_cpu_rdata", bus.cpu_rdata, 32'hDEAD_BEEF);
    chk("raw_dbg_rvalid", bus.dbg_rvalid, 1'b0);
    step();
    @(negedge clk);
    chk("dbg7_rvalid", bus.dbg_rvalid, 1'b1);
    chk("dbg7_rdata", bus.dbg_rdata, 32'h77);
    chk("dbg7_cpu_rvalid", bus.cpu_rvalid, 1'b0);
    step();

    // Interleaved reads from alternating owners.
    set_cpu(1'b1, 1'b0, 1, 32'h0);
    set_dbg(1'b1, 1'b0, 2, 32'h0);
    @(negedge clk); chk("il_cpu_gnt", bus.cpu_gnt, 1'b1);
    step(); bus.cpu_req = 1'b0;
    @(negedge clk); chk("il_dbg_gnt", bus.dbg_gnt, 1'b1);
    step(); bus.dbg_req = 1'b0;
    @(negedge clk);
    chk("il_cpu_rvalid", bus.cpu_rvalid, 1'b1);
    chk("il_cpu_rdata", bus.cpu_rdata, 32'h11);
    chk("il_dbg_rvalid0", bus.dbg_rvalid, 1'b0);
    step();
    @(negedge clk);
    chk("il_dbg_rvalid", bus.dbg_rvalid, 1'b1);
    chk("il_dbg_rdata", bus.dbg_rdata, 32'h22);
    chk("il_cpu_rvalid0", bus.cpu_rvalid, 1'b0);
    step();

    // Continuous contention: debug forced through after LIMIT denials.
    set_cpu(1'b1, 1'b0, 3, 32'h0);
    set_dbg(1'b1, 1'b0, 3, 32'h0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("ct_cpu_gnt", bus.cpu_gnt, i != 4);
      chk("ct_dbg_gnt", bus.dbg_gnt, i == 4);
      chk("ct_stall", bus.cpu_stall, i == 4);
      step();
    end
    bus.cpu_req = 1'b0; bus.dbg_req = 1'b0;
    repeat (3) step();

    // Lock with an idle debug port still stalls the CPU.
    bus.dbg_lock = 1'b1;
    set_cpu(1'b1, 1'b0, 4, 32'h0);
    repeat (3) begin
      @(negedge clk);
      chk("lk_cpu_gnt", bus.cpu_gnt, 1'b0);
      chk("lk_stall", bus.cpu_stall, 1'b1);
      chk("lk_rden", bus.ram_rden, 1'b0);
      chk("lk_wren", bus.ram_wren, 1'b0);
      step();
    end
    bus.dbg_lock = 1'b0;
    @(negedge clk); chk("lk_release_gnt", bus.cpu_gnt, 1'b1);
    step();

    // Reset right after an accepted read discards it.
    set_cpu(1'b1, 1'b0, 6, 32'h0);
    @(negedge clk); chk("mr_cpu_gnt", bus.cpu_gnt, 1'b1);
    step(); bus.cpu_req = 1'b0; reset = 1'b1;
    @(negedge clk); chk("mr_rvalid_rst", bus.cpu_rvalid, 1'b0);
    step(); reset = 1'b0;
    repeat (3) begin
      @(negedge clk); chk("mr_no_rvalid", bus.cpu_rvalid, 1'b0);
      step();
    end

    // Random traffic: requesters hold until granted, occasional lock and reset.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      c_done = bus.cpu_req & bus.cpu_gnt;
      d_done = bus.dbg_req & bus.dbg_gnt;
      step();
      reset = ($urandom_range(0, 299) == 0);
      if (bus.dbg_lock) bus.dbg_lock = ($urandom_range(0, 3) != 0);
      else bus.dbg_lock = ($urandom_range(0, 24) == 0);
      if (!bus.cpu_req || c_done)
        set_cpu($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), $urandom_range(0, 15), $urandom);
      if (!bus.dbg_req || d_done)
        set_dbg($urandom_range(0, 1) != 0, 1'($urandom_range(0, 1)), $urandom_range(0, 15), $urandom);
    end
    bus.cpu_req = 1'b0; bus.dbg_req = 1'b0; bus.dbg_lock = 1'b0; reset = 1'b0;
    repeat (RD_LAT + 3) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
